// File: rtl/rsa_pkg.sv
// Shared constants and helpers for the RSA modular-multiply datapath.
// Defaults here are picked up by the stage parameters.
package rsa_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam bit DEF_CLK_EDGE   = 1'b1;
    localparam bit DEF_START      = 1'b1;

    localparam logic START_ACTIVE = 1'b1;
    localparam logic DONE_ACTIVE  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rsa_core_mul.sv
// Shift-add multiplier producing the double-width product that feeds
// the modular-reduction stage (mul_done -> start, mul_p -> mod_a).
module rsa_core_mul
    import rsa_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit CLK_EDGE   = DEF_CLK_EDGE,
    parameter bit START      = DEF_START
) (
    input  logic                      mul_clk,
    input  logic                      mul_rst,
    input  logic                      mul_start,
    input  logic [DATA_WIDTH-1:0]     mul_a,
    input  logic [DATA_WIDTH-1:0]     mul_b,
    output logic                      mul_busy,
    output logic                      mul_done,
    output logic [2*DATA_WIDTH-1:0]   mul_p
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_CALC = 3'b001,
        S_DONE = 3'b010
    } state_e;

    // All architectural state in one bundle; the all-zero value is reset.
    typedef struct packed {
        state_e                st;
        logic [PW-1:0]         acc;
        logic [PW-1:0]         mcand;
        logic [DATA_WIDTH-1:0] mplr;
        logic [CW-1:0]         cnt;
        logic                  busy;
        logic                  done;
        logic [PW-1:0]         p;
    } regs_t;

    regs_t r_q;
    regs_t r_n;

    always_comb begin
        r_n      = r_q;
        r_n.done = ~DONE_ACTIVE;
        case (r_q.st)
            S_IDLE: begin
                if (mul_start == START) begin
                    r_n.acc   = '0;
                    r_n.mcand = {{DATA_WIDTH{1'b0}}, mul_a};
                    r_n.mplr  = mul_b;
                    r_n.cnt   = '0;
                    r_n.busy  = 1'b1;
                    r_n.st    = S_CALC;
                end
            end
            S_CALC: begin
                if (r_q.mplr[0]) begin
                    r_n.acc = r_q.acc + r_q.mcand;
                end
                r_n.mcand = r_q.mcand << 1;
                r_n.mplr  = r_q.mplr >> 1;
                r_n.cnt   = r_q.cnt + 1'b1;
                if (r_q.cnt == CNT_LAST) begin
                    r_n.st = S_DONE;
                end
            end
            S_DONE: begin
                r_n.p    = r_q.acc;
                r_n.done = DONE_ACTIVE;
                r_n.busy = 1'b0;
                r_n.st   = S_IDLE;
            end
            default: begin
                r_n.st = S_IDLE;
            end
        endcase
    end

    // Only the clock edge is selectable; reset is always posedge mul_rst.
    if (CLK_EDGE) begin : g_pos
        always_ff @(posedge mul_clk or posedge mul_rst) begin
            if (mul_rst) begin
                r_q <= '0;
            end else begin
                r_q <= r_n;
            end
        end
    end else begin : g_neg
        always_ff @(negedge mul_clk or posedge mul_rst) begin
            if (mul_rst) begin
                r_q <= '0;
            end else begin
                r_q <= r_n;
            end
        end
    end

    assign mul_busy = r_q.busy;
    assign mul_done = r_q.done;
    assign mul_p    = r_q.p;

endmodule
